// File: rtl/fft2d_pass_sequencer.sv
// Drives one streaming 1-D FFT core through the row pass and the column pass of an N x N 2-D FFT.
// Carries no sample data: config channel, tvalid/tlast, memory addressing, and done/err flags.
module fft2d_pass_sequencer #(
  parameter int          LOG2N    = 7,
  parameter logic [15:0] CFG_WORD = 16'h0001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               inv,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        cfg_tdata,
  output logic               cfg_tvalid,
  input  logic               cfg_tready,
  output logic               src_rd_en,
  output logic [2*LOG2N-1:0] src_addr,
  output logic               buf_rd_en,
  output logic [2*LOG2N-1:0] buf_rd_addr,
  output logic               buf_wr_en,
  output logic [2*LOG2N-1:0] buf_wr_addr,
  output logic               in_sel,
  output logic               fft_in_tvalid,
  output logic               fft_in_tlast,
  input  logic               fft_in_tready,
  input  logic               fft_out_tvalid,
  input  logic               fft_out_tlast,
  output logic               fft_out_tready,
  input  logic               fft_evt_err,
  output logic               res_valid,
  output logic               res_last,
  output logic [LOG2N-1:0]   res_row,
  output logic [LOG2N-1:0]   res_col
);
  localparam int AW = 2 * LOG2N;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    NN        = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0]    LAST      = NN - CW'(1);
  localparam logic [LOG2N-1:0] LANE_LAST = '1;

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_ROW, S_COL, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   ic, oc;
  logic            inv_l;
  logic            active, in_row, in_col, issue, beat, pass_end, tlast_bad;

  always_comb begin
    state_nxt = state;
    in_row    = (state == S_ROW);
    in_col    = (state == S_COL);
    active    = in_row || in_col;
    issue     = active && (ic < NN) && (!fft_in_tvalid || fft_in_tready);
    beat      = active && fft_out_tvalid;
    pass_end  = beat && (oc == LAST);
    tlast_bad = beat && (fft_out_tlast != (oc[LOG2N-1:0] == LANE_LAST));
    case (state)
      S_IDLE:  if (start) state_nxt = S_CFG;
      S_CFG:   if (cfg_tready) state_nxt = S_ROW;
      S_ROW:   if (pass_end) state_nxt = S_COL;
      S_COL:   if (pass_end) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != S_IDLE);
    done           = (state == S_DONE);
    cfg_tvalid     = (state == S_CFG);
    cfg_tdata      = cfg_tvalid ? {CFG_WORD[15:1], ~inv_l} : 16'h0000;
    src_rd_en      = issue && in_row;
    src_addr       = in_row ? ic[AW-1:0] : '0;
    // Column pass reads the transpose buffer with row = ic % N, col = ic / N
    buf_rd_en      = issue && in_col;
    buf_rd_addr    = in_col ? {ic[LOG2N-1:0], ic[AW-1:LOG2N]} : '0;
    buf_wr_en      = beat && in_row;
    buf_wr_addr    = in_row ? oc[AW-1:0] : '0;
    in_sel         = in_col;
    fft_out_tready = active;
    res_valid      = beat && in_col;
    res_last       = res_valid && fft_out_tlast;
    res_row        = in_col ? oc[LOG2N-1:0] : '0;
    res_col        = in_col ? oc[AW-1:LOG2N] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      ic            <= '0;
      oc            <= '0;
      inv_l         <= 1'b0;
      err           <= 1'b0;
      fft_in_tvalid <= 1'b0;
      fft_in_tlast  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        inv_l <= inv;
        err   <= 1'b0;
        ic    <= '0;
        oc    <= '0;
      end
      if (issue) ic <= ic + CW'(1);
      if (beat)  oc <= oc + CW'(1);
      // Both counters restart for the column pass; the row pass has fully drained here
      if (pass_end) begin
        ic <= '0;
        oc <= '0;
      end
      if (issue) begin
        fft_in_tvalid <= 1'b1;
        fft_in_tlast  <= (ic[LOG2N-1:0] == LANE_LAST);
      end else if (fft_in_tready) begin
        fft_in_tvalid <= 1'b0;
        fft_in_tlast  <= 1'b0;
      end
      if (active && (fft_evt_err || tlast_bad)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft2d_pass_sequencer.sv
// Directed bench for fft2d_pass_sequencer at LOG2N=2 (4x4 frame) with a 3-cycle passthrough core model.
module tb_fft2d_pass_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, inv;
  logic       busy, done, err;
  logic [15:0] cfg_tdata;
  logic       cfg_tvalid, cfg_tready;
  logic       src_rd_en, buf_rd_en, buf_wr_en, in_sel;
  logic [3:0] src_addr, buf_rd_addr, buf_wr_addr;
  logic       fft_in_tvalid, fft_in_tlast, fft_in_tready;
  logic       fft_out_tvalid, fft_out_tlast, fft_out_tready, fft_evt_err;
  logic       res_valid, res_last;
  logic [1:0] res_row, res_col;

  int n_chk = 0;
  int n_err = 0;

  // core model pipeline and control knobs
  logic p0v, p0l, p1v, p1l, p2v, p2l;
  logic tmode, drop7;

  // logs
  int          n_src, n_brd, n_bwr, n_res, n_done, n_last, hs_row, res_dup;
  logic [3:0]  src_log [32];
  logic [3:0]  brd_log [32];
  logic [3:0]  bwr_log [32];
  logic [31:0] tlast_mask;
  logic [15:0] res_mask;
  logic        err_b7, err_a7, chk_next;

  fft2d_pass_sequencer #(.LOG2N(2), .CFG_WORD(16'h0001)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv),
    .busy(busy), .done(done), .err(err),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .src_rd_en(src_rd_en), .src_addr(src_addr),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
    .in_sel(in_sel),
    .fft_in_tvalid(fft_in_tvalid), .fft_in_tlast(fft_in_tlast), .fft_in_tready(fft_in_tready),
    .fft_out_tvalid(fft_out_tvalid), .fft_out_tlast(fft_out_tlast), .fft_out_tready(fft_out_tready),
    .fft_evt_err(fft_evt_err),
    .res_valid(res_valid), .res_last(res_last), .res_row(res_row), .res_col(res_col)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    n_src = 0; n_brd = 0; n_bwr = 0; n_res = 0; n_done = 0; n_last = 0;
    hs_row = 0; res_dup = 0; tlast_mask = '0; res_mask = '0;
    err_b7 = 1'b0; err_a7 = 1'b0; chk_next = 1'b0;
  endtask

  task automatic do_start(input logic i);
    @(negedge clk); start = 1'b1; inv = i;
    @(negedge clk); start = 1'b0;
    #2;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 600) begin
      @(negedge clk); #2;
      k++;
    end
    check(tag, 64'(k < 600), 64'd1);
  endtask

  // core model + monitor: inputs updated at negedge, outputs sampled 1 time unit later
  initial begin
    clear_logs();
    {p0v, p0l, p1v, p1l, p2v, p2l} = '0;
    fft_in_tready = 1'b1; fft_out_tvalid = 1'b0; fft_out_tlast = 1'b0; fft_evt_err = 1'b0;
    forever begin
      @(negedge clk);
      fft_in_tready = tmode ? ~fft_in_tready : 1'b1;
      if (rst) begin
        {p0v, p0l, p1v, p1l, p2v, p2l} = '0;
        fft_out_tvalid = 1'b0; fft_out_tlast = 1'b0;
      end else begin
        fft_out_tvalid = p2v;
        fft_out_tlast  = p2l;
        if (drop7 && in_sel && n_res == 7) fft_out_tlast = 1'b0;
        p2v = p1v; p2l = p1l; p1v = p0v; p1l = p0l;
        p0v = fft_in_tvalid & fft_in_tready;
        p0l = fft_in_tlast & p0v;
      end
      #1;
      if (chk_next) begin err_a7 = err; chk_next = 1'b0; end
      if (src_rd_en) begin if (n_src < 32) src_log[n_src] = src_addr; n_src++; end
      if (buf_rd_en) begin if (n_brd < 32) brd_log[n_brd] = buf_rd_addr; n_brd++; end
      if (buf_wr_en) begin if (n_bwr < 32) bwr_log[n_bwr] = buf_wr_addr; n_bwr++; end
      if (fft_in_tvalid && fft_in_tready && !in_sel) begin
        if (fft_in_tlast && hs_row < 32) tlast_mask[hs_row] = 1'b1;
        hs_row++;
      end
      if (res_valid) begin
        if (res_mask[{res_row, res_col}]) res_dup++;
        res_mask[{res_row, res_col}] = 1'b1;
        if (res_last) n_last++;
        if (n_res == 7) begin err_b7 = err; chk_next = 1'b1; end
        n_res++;
      end
      if (done) n_done++;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; inv = 1'b0; cfg_tready = 1'b0; tmode = 1'b0; drop7 = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_outputs", {busy, done, err, cfg_tvalid, cfg_tdata, src_rd_en, src_addr,
           buf_rd_en, buf_rd_addr, buf_wr_en, buf_wr_addr, in_sel, fft_in_tvalid, fft_in_tlast,
           fft_out_tready, res_valid, res_last, res_row, res_col}, 64'd0);
    rst = 1'b0;

    // 1: forward transform, ideal core
    cfg_tready = 1'b1;
    clear_logs();
    do_start(1'b0);
    check("t1_cfg_tvalid", cfg_tvalid, 1);
    check("t1_cfg_tdata", cfg_tdata, 16'h0001);
    wait_idle("t1_timeout");
    check("t1_n_src", n_src, 16);
    check("t1_n_bwr", n_bwr, 16);
    check("t1_n_brd", n_brd, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t1_src_%0d", i), src_log[i], 64'(i));
      check($sformatf("t1_bwr_%0d", i), bwr_log[i], 64'(i));
      check($sformatf("t1_brd_%0d", i), brd_log[i], 64'((i % 4) * 4 + i / 4));
    end
    check("t1_done_once", n_done, 1);
    check("t1_err", err, 0);

    // 2: inverse, config held off for 5 cycles
    cfg_tready = 1'b0;
    clear_logs();
    do_start(1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_cfg_tvalid_%0d", i), cfg_tvalid, 1);
      check($sformatf("t2_cfg_tdata_%0d", i), cfg_tdata, 16'h0000);
      @(negedge clk); #2;
    end
    check("t2_no_row_before_accept", n_src, 0);
    cfg_tready = 1'b1;
    wait_idle("t2_timeout");
    check("t2_n_src", n_src, 16);
    check("t2_done_once", n_done, 1);

    // 3: input backpressure toggling during the passes
    tmode = 1'b1;
    clear_logs();
    do_start(1'b0);
    wait_idle("t3_timeout");
    tmode = 1'b0;
    check("t3_row_handshakes", hs_row, 16);
    check("t3_tlast_beats", tlast_mask, 32'h0000_8888);
    check("t3_n_src", n_src, 16);
    for (int i = 0; i < 16; i++) check($sformatf("t3_src_%0d", i), src_log[i], 64'(i));

    // 4: core drops tlast on column beat 7
    drop7 = 1'b1;
    clear_logs();
    do_start(1'b0);
    wait_idle("t4_timeout");
    drop7 = 1'b0;
    check("t4_err_before", err_b7, 0);
    check("t4_err_after", err_a7, 1);
    check("t4_err_sticky", err, 1);
    check("t4_done_once", n_done, 1);

    // 5: reset in the middle of the row pass
    clear_logs();
    do_start(1'b0);
    check("t5_err_cleared", err, 0);
    begin
      int k = 0;
      while (hs_row < 9 && k < 200) begin @(negedge clk); #2; k++; end
      check("t5_reach_beat9", 64'(k < 200), 1);
    end
    rst = 1'b1;
    @(negedge clk); #2;
    check("t5_rst_outputs", {busy, done, err, cfg_tvalid, cfg_tdata, src_rd_en, src_addr,
           buf_rd_en, buf_rd_addr, buf_wr_en, buf_wr_addr, in_sel, fft_in_tvalid, fft_in_tlast,
           fft_out_tready, res_valid, res_last, res_row, res_col}, 64'd0);
    rst = 1'b0;
    check("t5_no_done_on_rst", n_done, 0);
    clear_logs();
    do_start(1'b0);
    wait_idle("t5_timeout");
    check("t5_n_src", n_src, 16);
    check("t5_src_first", src_log[0], 0);
    check("t5_src_last", src_log[15], 15);
    check("t5_done_once", n_done, 1);
    check("t5_err", err, 0);

    // 6: start pulsed during the column pass is ignored
    clear_logs();
    do_start(1'b0);
    begin
      int k = 0;
      while (!in_sel && k < 200) begin @(negedge clk); #2; k++; end
      check("t6_reach_col", 64'(k < 200), 1);
    end
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    wait_idle("t6_timeout");
    repeat (10) @(negedge clk);
    #2;
    check("t6_stays_idle", busy, 0);
    check("t6_done_once", n_done, 1);
    check("t6_n_res", n_res, 16);
    check("t6_res_cover", res_mask, 16'hFFFF);
    check("t6_res_dup", res_dup, 0);
    check("t6_res_last", n_last, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
